// File: rtl/mdom_wvb_hdr_pkg.sv
// Shared definitions for the waveform-buffer header bundle: field positions,
// stream geometry, serializer state type and the waveform length helper.
package mdom_wvb_hdr_pkg;

  localparam int unsigned HDR_BUNDLE_W = 106;

  localparam int unsigned EVT_LTC_LSB      = 0;
  localparam int unsigned EVT_LTC_MSB      = 48;
  localparam int unsigned START_ADDR_LSB   = 49;
  localparam int unsigned START_ADDR_MSB   = 60;
  localparam int unsigned STOP_ADDR_LSB    = 61;
  localparam int unsigned STOP_ADDR_MSB    = 72;
  localparam int unsigned TRIG_SRC_LSB     = 73;
  localparam int unsigned TRIG_SRC_MSB     = 74;
  localparam int unsigned CNST_RUN_BIT     = 75;
  localparam int unsigned PRE_CONF_LSB     = 76;
  localparam int unsigned PRE_CONF_MSB     = 80;
  localparam int unsigned SYNC_RDY_BIT     = 81;
  localparam int unsigned BSUM_LSB         = 82;
  localparam int unsigned BSUM_MSB         = 100;
  localparam int unsigned BSUM_LEN_SEL_LSB = 101;
  localparam int unsigned BSUM_LEN_SEL_MSB = 103;
  localparam int unsigned BSUM_VALID_BIT   = 104;
  localparam int unsigned LOCAL_COINC_BIT  = 105;

  localparam int unsigned HDR_WORDS = 9;
  localparam int unsigned LAST_IDX  = HDR_WORDS - 1;

  localparam logic [3:0] HDR_TYPE_DEFAULT = 4'h1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } hdr_state_t;

  // Circular-buffer span inclusive of both ends: 1..4096 samples.
  function automatic logic [12:0] calc_wf_len(input logic [11:0] start_addr,
                                              input logic [11:0] stop_addr);
    logic [11:0] span;
    span = stop_addr - start_addr;
    return {1'b0, span} + 13'd1;
  endfunction

endpackage

// File: rtl/mdom_wvb_hdr_unpack.sv
// Combinational fan-out of the packed 106-bit header bundle into named fields.
module mdom_wvb_hdr_unpack
  import mdom_wvb_hdr_pkg::*;
(
  input  logic [HDR_BUNDLE_W-1:0] bundle,
  output logic [48:0]             evt_ltc,
  output logic [11:0]             start_addr,
  output logic [11:0]             stop_addr,
  output logic [1:0]              trig_src,
  output logic                    cnst_run,
  output logic [4:0]              pre_conf,
  output logic                    sync_rdy,
  output logic [18:0]             bsum,
  output logic [2:0]              bsum_len_sel,
  output logic                    bsum_valid,
  output logic                    local_coinc
);

  assign evt_ltc      = bundle[EVT_LTC_MSB:EVT_LTC_LSB];
  assign start_addr   = bundle[START_ADDR_MSB:START_ADDR_LSB];
  assign stop_addr    = bundle[STOP_ADDR_MSB:STOP_ADDR_LSB];
  assign trig_src     = bundle[TRIG_SRC_MSB:TRIG_SRC_LSB];
  assign cnst_run     = bundle[CNST_RUN_BIT];
  assign pre_conf     = bundle[PRE_CONF_MSB:PRE_CONF_LSB];
  assign sync_rdy     = bundle[SYNC_RDY_BIT];
  assign bsum         = bundle[BSUM_MSB:BSUM_LSB];
  assign bsum_len_sel = bundle[BSUM_LEN_SEL_MSB:BSUM_LEN_SEL_LSB];
  assign bsum_valid   = bundle[BSUM_VALID_BIT];
  assign local_coinc  = bundle[LOCAL_COINC_BIT];

endmodule

// File: rtl/mdom_wvb_hdr_serializer.sv
// Pops one header per waveform from the FWFT header FIFO and streams it as
// nine 16-bit words with a valid/ready handshake toward the readout arbiter.
module mdom_wvb_hdr_serializer
  import mdom_wvb_hdr_pkg::*;
#(
  parameter logic [3:0] CHAN_ID  = 4'd0,
  parameter logic [3:0] HDR_TYPE = HDR_TYPE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [HDR_BUNDLE_W-1:0] hdr_data,
  input  logic                    hdr_empty,
  output logic                    hdr_rdreq,
  output logic [15:0]             dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    busy,
  output logic [15:0]             hdr_cnt
);

  localparam logic [3:0] LAST_W = 4'(LAST_IDX);

  hdr_state_t              state;
  logic [HDR_BUNDLE_W-1:0] hdr_q;
  logic [3:0]              word_idx;

  logic                    start_hdr;
  logic [HDR_BUNDLE_W-1:0] fld_src;
  logic [3:0]              nxt_idx;
  logic [15:0]             nxt_word;
  logic [12:0]             wf_len;

  logic [48:0] evt_ltc;
  logic [11:0] start_addr;
  logic [11:0] stop_addr;
  logic [1:0]  trig_src;
  logic        cnst_run;
  logic [4:0]  pre_conf;
  logic        sync_rdy;
  logic [18:0] bsum;
  logic [2:0]  bsum_len_sel;
  logic        bsum_valid;
  logic        local_coinc;

  // The pop strobe must coincide with the cycle the FIFO head is latched, so it
  // is decoded from the state rather than registered.
  assign start_hdr = (state == ST_IDLE) && en && !hdr_empty;
  assign hdr_rdreq = start_hdr && !rst;

  // In IDLE the word mux looks at the FIFO head so W0 can be loaded on the pop
  // edge; once sending, it looks at the latched copy and the following index.
  assign fld_src = (state == ST_IDLE) ? hdr_data : hdr_q;
  assign nxt_idx = (state == ST_IDLE) ? '0 : word_idx + 4'd1;

  mdom_wvb_hdr_unpack u_unpack (
    .bundle       (fld_src),
    .evt_ltc      (evt_ltc),
    .start_addr   (start_addr),
    .stop_addr    (stop_addr),
    .trig_src     (trig_src),
    .cnst_run     (cnst_run),
    .pre_conf     (pre_conf),
    .sync_rdy     (sync_rdy),
    .bsum         (bsum),
    .bsum_len_sel (bsum_len_sel),
    .bsum_valid   (bsum_valid),
    .local_coinc  (local_coinc)
  );

  assign wf_len = calc_wf_len(start_addr, stop_addr);

  always_comb begin
    nxt_word = '0;
    case (nxt_idx)
      4'd0: nxt_word = {HDR_TYPE, 2'b00, trig_src, cnst_run, local_coinc,
                        sync_rdy, bsum_valid, bsum_len_sel, 1'b0};
      4'd1: nxt_word = evt_ltc[48:33];
      4'd2: nxt_word = evt_ltc[32:17];
      4'd3: nxt_word = evt_ltc[16:1];
      4'd4: nxt_word = {evt_ltc[0], 3'b000, start_addr};
      4'd5: nxt_word = {4'h0, stop_addr};
      4'd6: nxt_word = bsum[18:3];
      4'd7: nxt_word = {bsum[2:0], pre_conf, 4'h0, CHAN_ID};
      4'd8: nxt_word = {3'b000, wf_len};
      default: nxt_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      hdr_q      <= '0;
      word_idx   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      hdr_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_hdr) begin
            hdr_q      <= hdr_data;
            word_idx   <= nxt_idx;
            dout       <= nxt_word;
            dout_valid <= 1'b1;
            dout_last  <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (dout_ready) begin
            if (word_idx == LAST_W) begin
              dout       <= '0;
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
              busy       <= 1'b0;
              hdr_cnt    <= hdr_cnt + 16'd1;
              state      <= ST_IDLE;
            end else begin
              word_idx  <= nxt_idx;
              dout      <= nxt_word;
              dout_last <= (nxt_idx == LAST_W);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdom_wvb_hdr_serializer.sv
// Bench for mdom_wvb_hdr_serializer: FWFT FIFO model, word-level reference
// model and scoreboard, directed boundary cases plus randomized traffic.
module tb_mdom_wvb_hdr_serializer;

  localparam logic [3:0] TB_CHAN = 4'd3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [105:0] hdr_data = '0;
  logic         hdr_empty = 1'b1;
  logic         hdr_rdreq;
  logic [15:0]  dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         dout_last;
  logic         busy;
  logic [15:0]  hdr_cnt;

  mdom_wvb_hdr_serializer #(
    .CHAN_ID  (TB_CHAN),
    .HDR_TYPE (4'h1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .hdr_data   (hdr_data),
    .hdr_empty  (hdr_empty),
    .hdr_rdreq  (hdr_rdreq),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .hdr_cnt    (hdr_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [105:0] fifo[$];
  logic [15:0]  exp_q[$];
  logic [15:0]  seen[$];
  int           pop_cyc[$];
  int           w8_cyc[$];
  int           beat = 0;
  int           hs = 0;
  int           n_pops = 0;
  int           n_pushed = 0;
  int           cyc = 0;
  int           ready_mode = 0;
  logic [15:0]  exp_cnt = '0;
  logic         prev_hold = 1'b0;
  logic         prev_pop = 1'b0;
  logic [15:0]  prev_dout = '0;
  logic         prev_last = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] fld(input logic [105:0] b, input int lsb, input int w);
    logic [105:0] t;
    t = b >> lsb;
    return t[63:0] & ((64'd1 << w) - 64'd1);
  endfunction

  // Expected stream for one header, built field by field from the word map.
  function automatic void model_push(input logic [105:0] b);
    logic [63:0] evt, st, sp, trig, cr, pc, sr, bs, bl, bv, lc;
    int len;
    evt  = fld(b, 0, 49);   st = fld(b, 49, 12); sp = fld(b, 61, 12);
    trig = fld(b, 73, 2);   cr = fld(b, 75, 1);  pc = fld(b, 76, 5);
    sr   = fld(b, 81, 1);   bs = fld(b, 82, 19); bl = fld(b, 101, 3);
    bv   = fld(b, 104, 1);  lc = fld(b, 105, 1);
    len  = ((int'(sp) - int'(st) + 4096) % 4096) + 1;
    exp_q.push_back(16'((64'd1 << 12) | (trig << 8) | (cr << 7) | (lc << 6) |
                        (sr << 5) | (bv << 4) | (bl << 1)));
    exp_q.push_back(16'(evt >> 33));
    exp_q.push_back(16'(evt >> 17));
    exp_q.push_back(16'(evt >> 1));
    exp_q.push_back(16'(((evt & 64'd1) << 15) | st));
    exp_q.push_back(16'(sp));
    exp_q.push_back(16'(bs >> 3));
    exp_q.push_back(16'(((bs & 64'd7) << 13) | (pc << 8) | 64'(TB_CHAN)));
    exp_q.push_back(16'(len));
  endfunction

  function automatic logic [105:0] rnd_bundle();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[105:0];
  endfunction

  function automatic logic [105:0] mk(input logic [48:0] evt, input logic [11:0] st,
                                      input logic [11:0] sp, input logic [1:0] trig,
                                      input logic [18:0] bs);
    logic [105:0] b;
    b = 106'(evt) | (106'(st) << 49) | (106'(sp) << 61) | (106'(trig) << 73) |
        (106'(bs) << 82);
    return b;
  endfunction

  function automatic logic [15:0] sw(input int i);
    if (i < seen.size()) return seen[i];
    return 16'hDEAD;
  endfunction

  task automatic fifo_refresh();
    hdr_empty = (fifo.size() == 0);
    hdr_data  = hdr_empty ? rnd_bundle() : fifo[0];
  endtask

  task automatic push_hdr(input logic [105:0] b);
    fifo.push_back(b);
    n_pushed++;
    fifo_refresh();
  endtask

  // One clock: observe/score at negedge, apply pops and new inputs 1 after posedge.
  task automatic tick();
    logic do_pop;
    logic [15:0] w;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      check_eq("hdr_cnt", hdr_cnt, exp_cnt);
      check_eq("busy_valid", {busy, dout_valid}, {2{exp_q.size() != 0}});
      if (prev_hold)
        check_eq("hold", {dout_valid, dout_last, dout}, {1'b1, prev_last, prev_dout});
      if (prev_pop)
        check_eq("lat_w0", {dout_valid, 8'(beat)}, {1'b1, 8'd0});
      if (hdr_rdreq) begin
        check_eq("pop_ok", {hdr_empty, busy, dout_valid}, 3'b000);
        if (fifo.size() > 0) model_push(fifo[0]);
        n_pops++;
        pop_cyc.push_back(cyc);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_beat", 1, 0);
        end else begin
          w = exp_q.pop_front();
          check_eq($sformatf("word%0d", beat), dout, w);
          check_eq("last", dout_last, beat == 8);
          seen.push_back(dout);
          hs++;
          if (beat == 8) begin
            beat = 0;
            exp_cnt++;
            w8_cyc.push_back(cyc);
          end else begin
            beat++;
          end
        end
      end
    end
    prev_hold = !rst && dout_valid && !dout_ready;
    prev_pop  = !rst && hdr_rdreq;
    prev_dout = dout;
    prev_last = dout_last;
    do_pop    = !rst && hdr_rdreq;
    @(posedge clk);
    #1;
    if (do_pop && fifo.size() > 0) fifo.delete(0);
    fifo_refresh();
    case (ready_mode)
      0: dout_ready = 1'b1;
      1: dout_ready = ~dout_ready;
      2: dout_ready = ($urandom_range(0, 3) != 0);
      default: dout_ready = 1'b0;
    endcase
  endtask

  task automatic reset_model();
    exp_q.delete();
    beat = 0;
    hs = 0;
    exp_cnt = '0;
    prev_hold = 1'b0;
    prev_pop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ready_mode = 3;
    dout_ready = 1'b0;
    tick();
    reset_model();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_timeout"}, n >= budget, 0);
    tick();
  endtask

  initial begin
    int n, base;
    logic [105:0] b;
    logic [11:0] st_v[3] = '{12'd4090, 12'd100, 12'd0};
    logic [11:0] sp_v[3] = '{12'd5, 12'd100, 12'd4095};
    logic [15:0] ln_v[3] = '{16'd12, 16'd1, 16'h1000};

    fifo_refresh();
    repeat (3) tick();
    rst = 1'b0;
    ready_mode = 0;
    check_eq("rst_ctl", {hdr_rdreq, dout_valid, dout_last, busy}, 4'b0000);
    check_eq("rst_dout", dout, 16'h0000);
    check_eq("rst_cnt", hdr_cnt, 16'h0000);

    // Single header, always ready
    seen.delete(); pop_cyc.delete(); w8_cyc.delete();
    push_hdr(mk(49'h1_2345_6789_ABCD, 12'h010, 12'h0FF, 2'd2, 19'h7_FFFF));
    en = 1'b1;
    wait_idle(200, "single");
    check_eq("single_pops", n_pops, 1);
    check_eq("single_beats", seen.size(), 9);
    check_eq("single_w0", sw(0), 16'h1200);
    check_eq("single_w3", sw(3), 16'hD5E6);
    check_eq("single_w4", sw(4), 16'h8010);
    check_eq("single_w5", sw(5), 16'h00FF);
    check_eq("single_w6", sw(6), 16'hFFFF);
    check_eq("single_w7", sw(7), 16'hE003);
    check_eq("single_w8", sw(8), 16'h00F0);
    check_eq("single_span", w8_cyc.size() > 0 && pop_cyc.size() > 0 ? w8_cyc[0] - pop_cyc[0] : -1, 9);
    check_eq("single_cnt", hdr_cnt, 16'd1);

    // Backpressure: ready toggles every cycle
    ready_mode = 1;
    hs = 0;
    push_hdr(rnd_bundle());
    wait_idle(400, "bp");
    check_eq("bp_beats", hs, 9);

    // Waveform length wrap and boundaries
    ready_mode = 0;
    for (int i = 0; i < 3; i++) begin
      seen.delete();
      b = rnd_bundle();
      b[60:49] = st_v[i];
      b[72:61] = sp_v[i];
      push_hdr(b);
      wait_idle(200, "wflen");
      check_eq($sformatf("wflen%0d", i), sw(8), ln_v[i]);
    end

    // Back-to-back, three queued headers
    do_reset();
    ready_mode = 0;
    en = 1'b0;
    n_pops = 0; pop_cyc.delete(); w8_cyc.delete();
    for (int i = 0; i < 3; i++) push_hdr(rnd_bundle());
    en = 1'b1;
    wait_idle(400, "b2b");
    check_eq("b2b_pops", n_pops, 3);
    check_eq("b2b_gap1", pop_cyc.size() > 1 && w8_cyc.size() > 0 ? pop_cyc[1] - w8_cyc[0] : -1, 1);
    check_eq("b2b_gap2", pop_cyc.size() > 2 && w8_cyc.size() > 1 ? pop_cyc[2] - w8_cyc[1] : -1, 1);
    check_eq("b2b_cnt", hdr_cnt, 16'd3);

    // en dropped while header 2 is in flight
    base = n_pops;
    for (int i = 0; i < 3; i++) push_hdr(rnd_bundle());
    n = 0;
    while (n_pops < base + 2 && n < 300) begin tick(); n++; end
    check_eq("en_timeout", n >= 300, 0);
    en = 1'b0;
    n = 0;
    while (exp_cnt != 16'(base + 2) && n < 300) begin tick(); n++; end
    check_eq("en_done_timeout", n >= 300, 0);
    repeat (6) tick();
    check_eq("en_hold_pops", n_pops, base + 2);
    check_eq("en_hold_fifo", fifo.size(), 1);
    check_eq("en_hold_busy", busy, 1'b0);
    en = 1'b1;
    wait_idle(300, "en_resume");
    check_eq("en_resume_cnt", hdr_cnt, 16'd6);

    // Reset after the W3 handshake
    push_hdr(rnd_bundle());
    hs = 0;
    n = 0;
    while (hs < 4 && n < 100) begin tick(); n++; end
    check_eq("mid_timeout", n >= 100, 0);
    do_reset();
    check_eq("mid_rst_valid", dout_valid, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_cnt", hdr_cnt, 16'd0);
    ready_mode = 0;
    seen.delete();
    push_hdr(rnd_bundle());
    wait_idle(200, "after_rst");
    check_eq("after_rst_beats", hs, 9);
    check_eq("after_rst_cnt", hdr_cnt, 16'd1);

    // hdr_cnt wrap from 16'hFFFF
    force dut.hdr_cnt = 16'hFFFF;
    #1;
    release dut.hdr_cnt;
    exp_cnt = 16'hFFFF;
    push_hdr(rnd_bundle());
    wait_idle(200, "wrap");
    check_eq("cnt_wrap", hdr_cnt, 16'h0000);

    // Randomized traffic: random pushes, en and ready
    ready_mode = 2;
    n_pops = 0;
    n_pushed = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) push_hdr(rnd_bundle());
      en = ($urandom_range(0, 4) != 0);
      tick();
    end
    en = 1'b1;
    wait_idle(3000, "rand");
    check_eq("rand_pops", n_pops, n_pushed);
    check_eq("rand_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
